pwm_multi_ch: RTL

//  Multi-channel PWM generator with button-driven duty control; successor to the single-channel 10-step PWM.
//  One shared period counter drives NUM_CH comparators. The counter runs edge-aligned (sawtooth) or

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_debounce.sv | 27 ++
 rtl/pwm_multi_ch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode encoding, duty defaults and width helper for the multi-channel PWM
package pwm_pkg;

   // counter shape held in mode_act
   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_t;

   localparam int DUTY_INIT_DEF = 5;
   localparam int DUTY_MIN_DEF  = 1;
   localparam int DUTY_MAX_DEF  = 9;

   // ceil(log2(n)), never below 1 so derived vector widths stay legal
   function automatic int pwm_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/pwm_debounce.sv
// rtl/pwm_debounce.sv - two-stage tick-sampled button debouncer with one-cycle press pulse
module pwm_debounce (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn,
   output logic press
);

   logic s1;
   logic s2;

   // sample the raw button only on the shared slow tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else if (tick) begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   // rising edge of the sampled level, qualified by tick so it lasts one clk
   assign press = tick & s1 & ~s2;

endmodule

// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel edge/centre-aligned PWM with debounced duty buttons
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 8,
   parameter int PERIOD    = 10,
   parameter int DUTY_INIT = DUTY_INIT_DEF,
   parameter int DUTY_MIN  = DUTY_MIN_DEF,
   parameter int DUTY_MAX  = DUTY_MAX_DEF,
   parameter int DEB_DIV   = 2,
   localparam int SEL_W    = pwm_clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              btn_inc,
   input  logic              btn_dec,
   input  logic [SEL_W-1:0]  ch_sel,
   input  logic              center_mode,
   input  logic [NUM_CH-1:0] invert,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start,
   output logic [CNT_W-1:0]  duty_sel
);

   localparam int DIV_W = pwm_clog2(DEB_DIV);
   localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(DEB_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] D_INIT  = CNT_W'(DUTY_INIT);
   localparam logic [CNT_W-1:0] D_MIN   = CNT_W'(DUTY_MIN);
   localparam logic [CNT_W-1:0] D_MAX   = CNT_W'(DUTY_MAX);

   logic [DIV_W-1:0]  div;
   logic              tick;
   logic              ev_inc;
   logic              ev_dec;
   logic              sel_ok;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              dir_up;
   logic              dir_nxt;
   logic              boundary;
   pwm_mode_t         mode_act;
   logic [NUM_CH-1:0] pwm_nxt;
   logic [CNT_W-1:0]  duty_shadow [NUM_CH];
   logic [CNT_W-1:0]  duty_act    [NUM_CH];

   assign tick   = (div == DIV_TOP);
   assign sel_ok = (int'(ch_sel) < NUM_CH);

   // free-running divider that paces both debouncers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div <= '0;
      else        div <= tick ? '0 : div + 1'b1;
   end

   pwm_debounce u_deb_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .btn   (btn_inc),
      .press (ev_inc)
   );

   pwm_debounce u_deb_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .btn   (btn_dec),
      .press (ev_dec)
   );

   // button events nudge the addressed shadow duty, clamped to [DUTY_MIN, DUTY_MAX]; runs regardless of ena
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) duty_shadow[i] <= D_INIT;
      end else if (sel_ok && (ev_inc ^ ev_dec)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_sel) == i) begin
               if (ev_inc && (duty_shadow[i] < D_MAX))      duty_shadow[i] <= duty_shadow[i] + 1'b1;
               else if (ev_dec && (duty_shadow[i] > D_MIN)) duty_shadow[i] <= duty_shadow[i] - 1'b1;
            end
         end
      end
   end

   // next count: sawtooth wraps at the top, triangle turns round at the top and ends at 0
   always_comb begin
      cnt_nxt = cnt + 1'b1;
      dir_nxt = dir_up;
      if (mode_act == PWM_CENTER) begin
         if (!dir_up || (cnt == CNT_TOP)) begin
            cnt_nxt = cnt - 1'b1;
            dir_nxt = 1'b0;
         end
      end else if (cnt == CNT_TOP) begin
         cnt_nxt = '0;
      end
   end

   assign boundary = ena && (cnt_nxt == '0);

   // period counter; duties and mode are only swapped in at a period boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         dir_up       <= 1'b1;
         mode_act     <= PWM_EDGE;
         period_start <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) duty_act[i] <= D_INIT;
      end else begin
         period_start <= boundary;
         if (ena) begin
            cnt    <= cnt_nxt;
            dir_up <= boundary ? 1'b1 : dir_nxt;
            if (boundary) begin
               mode_act <= pwm_mode_t'(center_mode);
               for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_shadow[i];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign pwm_nxt[g] = (cnt < duty_act[g]) ^ invert[g];
   end

   // comparator outputs are registered and hold while the counter is paused
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   pwm_out <= '0;
      else if (ena) pwm_out <= pwm_nxt;
   end

   // active duty of the addressed channel, zero when out of range
   always_comb begin
      duty_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(ch_sel) == i) duty_sel = duty_act[i];
      end
   end

endmodule
